// File: rtl/inst_fetch_queue.sv
// In-order Fetch-to-Decode instruction queue: FETCH_W lanes in, ISSUE_W lanes out, DEPTH-entry ring.
// Optional same-cycle enqueue-to-dequeue bypass when empty: define INST_FETCH_QUEUE_BYPASS_EN.
module inst_fetch_queue #(
   parameter int WIDTH   = 32,
   parameter int FETCH_W = 2,
   parameter int ISSUE_W = 2,
   parameter int DEPTH   = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [FETCH_W-1:0]             enq_valid,
   input  logic [FETCH_W*WIDTH-1:0]       enq_inst,
   input  logic [FETCH_W*WIDTH-1:0]       enq_pc,
   input  logic [FETCH_W-1:0]             enq_bp_taken,
   output logic                           enq_ready,
   output logic [ISSUE_W-1:0]             deq_valid,
   output logic [ISSUE_W*WIDTH-1:0]       deq_inst,
   output logic [ISSUE_W*WIDTH-1:0]       deq_pc,
   output logic [ISSUE_W-1:0]             deq_bp_taken,
   input  logic [$clog2(ISSUE_W+1)-1:0]   deq_take,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           full,
   output logic                           empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int BW = (FETCH_W < ISSUE_W) ? FETCH_W : ISSUE_W;

   logic [WIDTH-1:0] inst_mem_r [DEPTH];
   logic [WIDTH-1:0] pc_mem_r   [DEPTH];
   logic             bp_mem_r   [DEPTH];

   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;

   logic [CW-1:0] n_run_s;
   logic          run_s;
   logic [CW-1:0] n_enq_s;
   logic [CW-1:0] n_deq_s;
   logic [CW-1:0] avail_s;
   logic [CW-1:0] take_s;
   logic [CW-1:0] skip_s;
   logic          bypass_s;

   assign count     = count_r;
   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign enq_ready = ((CW'(DEPTH) - count_r) >= CW'(FETCH_W));

   // Accepted lanes: leading run of valid lanes, none when the queue cannot take a full group.
   always_comb begin
      n_run_s = {CW{1'b0}};
      run_s   = 1'b1;
      for (int i = 0; i < FETCH_W; i++) begin
         if (run_s && enq_valid[i]) begin
            n_run_s = n_run_s + CW'(1);
         end else begin
            run_s = 1'b0;
         end
      end
      if (enq_ready) begin
         n_enq_s = n_run_s;
      end else begin
         n_enq_s = {CW{1'b0}};
      end
   end

   // Dequeue count clamped to what is visible; with bypass, an empty queue exposes the incoming lanes.
   always_comb begin
      avail_s  = count_r;
      skip_s   = {CW{1'b0}};
      bypass_s = 1'b0;
      take_s   = CW'(deq_take);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      bypass_s = (count_r == {CW{1'b0}}) && !flush;
      if (bypass_s) begin
         avail_s = n_enq_s;
      end else begin
         avail_s = count_r;
      end
`endif
      if (take_s > avail_s) begin
         n_deq_s = avail_s;
      end else begin
         n_deq_s = take_s;
      end
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      if (bypass_s) begin
         skip_s = n_deq_s;
      end else begin
         skip_s = {CW{1'b0}};
      end
`endif
   end

   // First-word-fall-through head lanes, optionally overridden by the bypass path.
   always_comb begin
      for (int i = 0; i < ISSUE_W; i++) begin
         deq_valid[i]              = (count_r > CW'(i));
         deq_inst[i*WIDTH +: WIDTH] = inst_mem_r[head_r + PW'(i)];
         deq_pc[i*WIDTH +: WIDTH]   = pc_mem_r[head_r + PW'(i)];
         deq_bp_taken[i]            = bp_mem_r[head_r + PW'(i)];
      end
      if (bypass_s) begin
         for (int i = 0; i < ISSUE_W; i++) begin
            deq_valid[i] = (CW'(i) < n_enq_s);
         end
         for (int i = 0; i < BW; i++) begin
            deq_inst[i*WIDTH +: WIDTH] = enq_inst[i*WIDTH +: WIDTH];
            deq_pc[i*WIDTH +: WIDTH]   = enq_pc[i*WIDTH +: WIDTH];
            deq_bp_taken[i]            = enq_bp_taken[i];
         end
      end else begin
         deq_valid = deq_valid;
      end
   end

   // Pointer and occupancy registers; flush clears everything and overrides traffic.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else if (flush) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         head_r  <= head_r + PW'(n_deq_s);
         tail_r  <= tail_r + PW'(n_enq_s);
         count_r <= count_r + n_enq_s - n_deq_s;
      end
   end

   // Entry storage; lanes already consumed through the bypass are not written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_W; i++) begin
         if (!flush && (CW'(i) < n_enq_s) && (CW'(i) >= skip_s)) begin
            inst_mem_r[tail_r + PW'(i)] <= enq_inst[i*WIDTH +: WIDTH];
            pc_mem_r[tail_r + PW'(i)]   <= enq_pc[i*WIDTH +: WIDTH];
            bp_mem_r[tail_r + PW'(i)]   <= enq_bp_taken[i];
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue (defaults: WIDTH=32, FETCH_W=2, ISSUE_W=2, DEPTH=8).
// Reference model is a queue of entries updated once per clock edge.
module tb_inst_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [1:0]  enq_valid;
   logic [63:0] enq_inst;
   logic [63:0] enq_pc;
   logic [1:0]  enq_bp_taken;
   logic        enq_ready;
   logic [1:0]  deq_valid;
   logic [63:0] deq_inst;
   logic [63:0] deq_pc;
   logic [1:0]  deq_bp_taken;
   logic [1:0]  deq_take;
   logic [3:0]  count;
   logic        full;
   logic        empty;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        bp;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;

   inst_fetch_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_inst(enq_inst), .enq_pc(enq_pc),
      .enq_bp_taken(enq_bp_taken), .enq_ready(enq_ready),
      .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_pc(deq_pc),
      .deq_bp_taken(deq_bp_taken), .deq_take(deq_take),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   function automatic int cur_ne();
      int n = 0;
      if (q.size() <= 6 && enq_valid[0]) begin
         n = 1;
         if (enq_valid[1]) n = 2;
      end
      return n;
   endfunction

   function automatic int exp_nvis();
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      if (q.size() == 0 && !flush) return cur_ne();
`endif
      return q.size();
   endfunction

   function automatic ent_t lane_ent(int i);
      ent_t e;
      e.inst = enq_inst[i*32 +: 32];
      e.pc   = enq_pc[i*32 +: 32];
      e.bp   = enq_bp_taken[i];
      return e;
   endfunction

   function automatic ent_t exp_ent(int i);
      if (q.size() > 0) return q[i];
      return lane_ent(i);
   endfunction

   task automatic drive(input logic fl, input logic [1:0] v, input logic [31:0] pc0,
                        input logic [31:0] pc1, input logic [1:0] take);
      flush        = fl;
      enq_valid    = v;
      enq_pc       = {pc1, pc0};
      enq_inst     = {$urandom, $urandom};
      enq_bp_taken = 2'($urandom);
      deq_take     = take;
      #2;
   endtask

   task automatic tick();
      int vis, nd, ne;
      if (flush) begin
         q.delete();
      end else begin
         ne  = cur_ne();
         vis = exp_nvis();
         for (int k = 0; k < ne; k++) q.push_back(lane_ent(k));
         nd = (int'(deq_take) < vis) ? int'(deq_take) : vis;
         repeat (nd) void'(q.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      flush = 1'b0; enq_valid = 2'b00; deq_take = 2'd0;
      rst = 1'b0;
      #1;
      q.delete();
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
      checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", enq_ready); end
      checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL reset_deq_valid got %b want 00", deq_valid); end
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill_drain();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 2'b11, 32'(8*k), 32'(8*k+4), 2'd0);
         checks++; if (count !== 4'(2*k)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, 2*k); end
         checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL fill_ready got %0b want 1", enq_ready); end
         tick();
      end
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd0);
      checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", count); end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %0b want 1", full); end
      checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", enq_ready); end
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd2);
         checks++; if (deq_valid !== 2'b11) begin errors++; $display("FAIL drain_valid got %b want 11", deq_valid); end
         checks++;
         if (deq_pc !== {32'(8*k+4), 32'(8*k)}) begin
            errors++; $display("FAIL drain_pc got %h want %h", deq_pc, {32'(8*k+4), 32'(8*k)});
         end
         tick();
      end
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd0);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drained_empty got %0b want 1", empty); end
      checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL drained_valid got %b want 00", deq_valid); end
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 2'b11, 32'(32'h100 + 8*k), 32'(32'h104 + 8*k), 2'd0); tick();
      end
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd2); tick();
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 2'b11, 32'(32'h118 + 8*k), 32'(32'h11C + 8*k), 2'd0); tick();
      end
      drive(1'b0, 2'b11, 32'h128, 32'h12C, 2'd1);
      checks++; if (count !== 4'd4) begin errors++; $display("FAIL wrap_pre_count got %0d want 4", count); end
      checks++; if (deq_pc[31:0] !== 32'h118) begin errors++; $display("FAIL wrap_head_pc got %h want 118", deq_pc[31:0]); end
      tick();
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd0);
      checks++; if (count !== 4'd5) begin errors++; $display("FAIL wrap_count got %0d want 5", count); end
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd1);
         checks++;
         if (deq_pc[31:0] !== 32'(32'h11C + 4*k)) begin
            errors++; $display("FAIL wrap_lane0 got %h want %h", deq_pc[31:0], 32'(32'h11C + 4*k));
         end
         if (k < 4) begin
            checks++;
            if (deq_pc[63:32] !== 32'(32'h120 + 4*k)) begin
               errors++; $display("FAIL wrap_lane1 got %h want %h", deq_pc[63:32], 32'(32'h120 + 4*k));
            end
         end
         tick();
      end
   endtask

   task automatic test_noncontig_clamp();
      drive(1'b0, 2'b01, 32'h200, 32'h0, 2'd0); tick();
      drive(1'b0, 2'b10, 32'h300, 32'h304, 2'd0); tick();
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd0);
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL noncontig_count got %0d want 1", count); end
      checks++; if (deq_pc[31:0] !== 32'h200) begin errors++; $display("FAIL noncontig_pc got %h want 200", deq_pc[31:0]); end
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd2); tick();
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd0);
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL clamp_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clamp_empty got %0b want 1", empty); end
   endtask

   task automatic test_flush();
      drive(1'b0, 2'b11, 32'h10, 32'h14, 2'd0); tick();
      drive(1'b0, 2'b11, 32'h18, 32'h1C, 2'd0); tick();
      drive(1'b0, 2'b01, 32'h20, 32'h0, 2'd0); tick();
      drive(1'b1, 2'b11, 32'h500, 32'h504, 2'd2);
      checks++; if (count !== 4'd5) begin errors++; $display("FAIL preflush_count got %0d want 5", count); end
      tick();
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd0);
      checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %0b want 1", empty); end
      checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL flush_valid got %b want 00", deq_valid); end
      drive(1'b0, 2'b01, 32'h40, 32'h0, 2'd0); tick();
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd0);
      checks++; if (deq_valid !== 2'b01) begin errors++; $display("FAIL postflush_valid got %b want 01", deq_valid); end
      checks++; if (deq_pc[31:0] !== 32'h40) begin errors++; $display("FAIL postflush_pc got %h want 40", deq_pc[31:0]); end
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd1); tick();
   endtask

   task automatic test_bypass();
      drive(1'b0, 2'b11, 32'h80, 32'h84, 2'd1);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      checks++; if (deq_valid !== 2'b11) begin errors++; $display("FAIL bypass_valid got %b want 11", deq_valid); end
      checks++; if (deq_pc[31:0] !== 32'h80) begin errors++; $display("FAIL bypass_pc got %h want 80", deq_pc[31:0]); end
`else
      checks++; if (deq_valid !== 2'b00) begin errors++; $display("FAIL nobypass_valid got %b want 00", deq_valid); end
`endif
      tick();
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd0);
`ifdef INST_FETCH_QUEUE_BYPASS_EN
      checks++; if (count !== 4'd1) begin errors++; $display("FAIL bypass_count got %0d want 1", count); end
      checks++; if (deq_pc[31:0] !== 32'h84) begin errors++; $display("FAIL bypass_head got %h want 84", deq_pc[31:0]); end
`else
      checks++; if (count !== 4'd2) begin errors++; $display("FAIL nobypass_count got %0d want 2", count); end
      checks++; if (deq_pc[31:0] !== 32'h80) begin errors++; $display("FAIL nobypass_head got %h want 80", deq_pc[31:0]); end
`endif
      drive(1'b0, 2'b00, 32'd0, 32'd0, 2'd3); tick();
   endtask

   task automatic test_random();
      int   nv;
      ent_t e;
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 2'($urandom), $urandom, $urandom,
               (c < 200) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3)));
         nv = exp_nvis();
         checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count got %0d want %0d", count, q.size()); end
         checks++; if (enq_ready !== (q.size() <= 6)) begin errors++; $display("FAIL rnd_ready got %0b want %0b", enq_ready, q.size() <= 6); end
         checks++; if (full !== (q.size() == 8)) begin errors++; $display("FAIL rnd_full got %0b want %0b", full, q.size() == 8); end
         checks++; if (empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty got %0b want %0b", empty, q.size() == 0); end
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (deq_valid[i] !== (i < nv)) begin
               errors++; $display("FAIL rnd_valid lane %0d got %0b want %0b", i, deq_valid[i], i < nv);
            end
            if (i < nv) begin
               e = exp_ent(i);
               checks++;
               if ({deq_inst[i*32 +: 32], deq_pc[i*32 +: 32], deq_bp_taken[i]} !== e) begin
                  errors++;
                  $display("FAIL rnd_data lane %0d got %h/%h/%0b want %h/%h/%0b", i,
                           deq_inst[i*32 +: 32], deq_pc[i*32 +: 32], deq_bp_taken[i], e.inst, e.pc, e.bp);
               end
            end
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; enq_valid = 2'b00; enq_inst = 64'd0; enq_pc = 64'd0;
      enq_bp_taken = 2'b00; deq_take = 2'd0;
      #12;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_noncontig_clamp();
      test_flush();
      test_bypass();
      test_random();
      test_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
